// File: rtl/kp_i2s_out.sv
// Karplus-Strong output stage: attenuate, optionally DC-block, serialise as mono Philips I2S.
// Define KP_I2S_DC_BLOCK_EN to insert the one-pole DC blocker ahead of the sample hold register.
module kp_i2s_out #(
    parameter int unsigned BCLK_DIV = 4,
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic        a_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [23:0] din,
    input  logic        din_valid,
    input  logic [2:0]  attn,
    output logic        frame_req,
    output logic        underrun,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata
);

    if (BCLK_DIV < 1 || BCLK_DIV > 255 || DC_SHIFT > 23) begin : g_param_check
        $error("kp_i2s_out: BCLK_DIV or DC_SHIFT out of range");
    end

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_nxt;
    logic [63:0] shreg;
    logic [23:0] hold;
    logic        fresh;
    logic [23:0] x;
    logic [23:0] hold_d;
    logic        hold_we;

    always_comb begin
        x       = $signed(din) >>> attn;
        bit_nxt = bit_cnt + 6'd1;
    end

`ifdef KP_I2S_DC_BLOCK_EN
    logic [23:0] x_prev;
    logic [23:0] y_prev;
    logic [23:0] y_dec;
    logic [27:0] y_full;
    logic [23:0] y_sat;
    logic        dc_valid;

    always_comb begin
        y_dec  = $signed(y_prev) >>> DC_SHIFT;
        y_full = {{4{x[23]}}, x} - {{4{x_prev[23]}}, x_prev}
               + {{4{y_prev[23]}}, y_prev} - {{4{y_dec[23]}}, y_dec};
        if (y_full[27:23] == 5'b00000 || y_full[27:23] == 5'b11111)
            y_sat = y_full[23:0];
        else
            y_sat = y_full[27] ? 24'h800000 : 24'h7FFFFF;
    end

    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            x_prev   <= '0;
            y_prev   <= '0;
            dc_valid <= 1'b0;
        end else begin
            dc_valid <= din_valid;
            if (din_valid) begin
                x_prev <= x;
                y_prev <= y_sat;
            end
        end
    end

    // y_prev doubles as the pipeline register feeding hold one cycle later
    always_comb begin
        hold_we = dc_valid;
        hold_d  = y_prev;
    end
`else
    always_comb begin
        hold_we = din_valid;
        hold_d  = x;
    end
`endif

    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            fresh     <= 1'b0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            frame_req <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            frame_req <= 1'b0;
            underrun  <= 1'b0;
            if (hold_we)
                hold <= hold_d;
            case (state)
                IDLE: begin
                    bclk    <= 1'b0;
                    lrclk   <= 1'b0;
                    sdata   <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bclk    <= ~bclk;
                        if (bclk) begin
                            bit_cnt <= bit_nxt;
                            lrclk   <= bit_nxt[5];
                            if (bit_nxt == 6'd0) begin
                                if (!enable) begin
                                    state <= IDLE;
                                    sdata <= 1'b0;
                                end else begin
                                    // shreg takes the pre-update hold even if hold_we fires now
                                    shreg     <= {hold, 8'h00, hold, 8'h00};
                                    sdata     <= 1'b0;
                                    frame_req <= 1'b1;
                                    underrun  <= ~fresh;
                                    fresh     <= 1'b0;
                                end
                            end else begin
                                sdata <= shreg[63];
                                shreg <= {shreg[62:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // a sample landing on the frame-start edge still counts for the next frame
            if (hold_we)
                fresh <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kp_i2s_out.sv
// Scoreboard bench for kp_i2s_out: frame-level reference model feeds a queue, a monitor deserialises I2S.
module tb_kp_i2s_out;
    localparam int BD  = 2;
    localparam int DCS = 8;
    localparam int P   = 128 * BD;
`ifdef KP_I2S_DC_BLOCK_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int END_RESET   = 0;
    localparam int END_DISABLE = 1;

    logic        a_clk     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        din_valid = 1'b0;
    logic [23:0] din       = '0;
    logic [2:0]  attn      = '0;
    logic        frame_req, underrun, bclk, lrclk, sdata;

    kp_i2s_out #(.BCLK_DIV(BD), .DC_SHIFT(DCS)) dut (
        .a_clk     (a_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .din       (din),
        .din_valid (din_valid),
        .attn      (attn),
        .frame_req (frame_req),
        .underrun  (underrun),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata)
    );

    always #5 a_clk = ~a_clk;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
    } exp_t;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_frames = 0;
    int   stray    = 0;
    bit   abort    = 0;
    int   g        = 0;

    int   m_hold;
    bit   m_fresh;
    bit   carry_v;
    int   carry_d;
`ifdef KP_I2S_DC_BLOCK_EN
    int   xp, yp;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_bclk"},      64'(bclk),      64'(0));
        check({pfx, "_lrclk"},     64'(lrclk),     64'(0));
        check({pfx, "_sdata"},     64'(sdata),     64'(0));
        check({pfx, "_frame_req"}, 64'(frame_req), 64'(0));
        check({pfx, "_underrun"},  64'(underrun),  64'(0));
    endtask

    // Reference: attenuated (and optionally DC-blocked) sample value from plain integer math
    function automatic int ref_sample(input logic [23:0] d, input logic [2:0] a);
        int x;
        x = {{8{d[23]}}, d};
        x = x >>> a;
`ifdef KP_I2S_DC_BLOCK_EN
        begin
            int y;
            y = x - xp + yp - (yp >>> DCS);
            if (y > 8388607) y = 8388607;
            else if (y < -8388608) y = -8388608;
            xp = x;
            yp = y;
            return y;
        end
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        exp_t e;
        m_hold  = 0;
        m_fresh = 0;
        carry_v = 0;
        carry_d = 0;
`ifdef KP_I2S_DC_BLOCK_EN
        xp = 0;
        yp = 0;
`endif
        q.delete();
        e.d = '0;
        e.u = 1'b1;
        q.push_back(e);
    endtask

    task automatic wait_frame_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 * BD + 50; i++) begin
            @(negedge a_clk);
            if (frame_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Each iteration starts on the negedge where frame_req is visible (offset 0)
    task automatic run_phase(input int nframes, input int ending);
        bit          ok, last, rnd;
        int          ns, v, t, fr_cnt, ln_cnt;
        int          o[2];
        logic [23:0] dv[2];
        logic [2:0]  av[2];
        logic [23:0] d;
        logic [2:0]  a;
        exp_t        e;
        wait_frame_req(ok);
        if (!ok) begin
            check("first_frame_req", 64'(frame_req), 64'(1));
            abort = 1;
            return;
        end
        for (int f = 0; f < nframes; f++) begin
            last = (f == nframes - 1);
            if (carry_v) begin
                m_hold  = carry_d;
                m_fresh = 1;
                carry_v = 0;
            end
            ns = 0; rnd = 0;
            o[0] = 0; o[1] = 0;
            dv[0] = '0; dv[1] = '0; av[0] = '0; av[1] = '0;
            if (last) begin
                ns = 0;
            end else if (ending == END_RESET && f == nframes - 2) begin
                ns = 1; o[0] = 3; dv[0] = 24'h7FFFFF;
            end else begin
                case (g)
                    0: begin ns = 1; o[0] = 10;          dv[0] = 24'h7FFFFF; end
                    1: begin ns = 1; o[0] = 100;         dv[0] = 24'h800000; av[0] = 3'd3; end
                    2: begin ns = 1; o[0] = 5;           dv[0] = 24'h000001; end
                    3: begin ns = 1; o[0] = 0;           dv[0] = 24'h123456; end
                    4: begin ns = 1; o[0] = P - 1;       dv[0] = 24'h0ABCDE; end
                    5: ns = 0;
                    6: begin ns = 1; o[0] = P - 1 - LAT; dv[0] = 24'h654321; av[0] = 3'd1; end
                    default: begin
                        rnd  = 1;
                        ns   = $urandom_range(0, 2);
                        o[0] = $urandom_range(0, P - 1);
                        o[1] = $urandom_range(0, P - 1);
                        if (o[1] < o[0]) begin t = o[0]; o[0] = o[1]; o[1] = t; end
                        if (ns == 2 && o[0] == o[1]) ns = 1;
                    end
                endcase
            end
            g++;
            for (int j = 0; j < P; j++) begin
                din_valid = 1'b0;
                if (j == 1)
                    check("frame_req_width", 64'(frame_req), 64'(0));
                for (int k = 0; k < ns; k++) begin
                    if (j == o[k]) begin
                        d = rnd ? 24'($urandom) : dv[k];
                        a = rnd ? 3'($urandom_range(0, 7)) : av[k];
                        din = d; attn = a; din_valid = 1'b1;
                        v = ref_sample(d, a);
                        if (j + LAT <= P - 1) begin
                            m_hold  = v;
                            m_fresh = 1;
                        end else begin
                            carry_d = v;
                            carry_v = 1;
                        end
                    end
                end
                if (last && ending == END_RESET && j == 80 * BD + 1) begin
                    reset_n = 1'b0;
                    @(negedge a_clk);
                    din_valid = 1'b0;
                    check_quiet("midframe_reset");
                    q.delete();
                    return;
                end
                if (last && ending == END_DISABLE && j == 20 * BD + 1)
                    enable = 1'b0;
                if (j == P - 1 && !last) begin
                    e.d = m_hold[23:0];
                    e.u = ~m_fresh;
                    q.push_back(e);
                    m_fresh = 0;
                end
                @(negedge a_clk);
            end
            din_valid = 1'b0;
            if (last) begin
                check_quiet("disabled");
                fr_cnt = 0; ln_cnt = 0;
                for (int i = 0; i < 2 * P; i++) begin
                    @(negedge a_clk);
                    if (frame_req) fr_cnt++;
                    if (bclk || lrclk || sdata) ln_cnt++;
                end
                check("idle_frame_req", 64'(fr_cnt), 64'(0));
                check("idle_lines", 64'(ln_cnt), 64'(0));
                return;
            end
            check("frame_period", 64'(frame_req), 64'(1));
        end
    endtask

    // Monitor: pop one expectation per frame_req, deserialise 64 bclk rises
    exp_t        cur;
    bit          mon_active = 0;
    logic        bclk_prev  = 1'b0;
    logic [63:0] dw, lw;
    int          nbits, cyc;

    always @(negedge a_clk) begin
        if (!reset_n) begin
            mon_active = 0;
            bclk_prev  = 1'b0;
        end else begin
            if (underrun && !frame_req) stray++;
            if (frame_req) begin
                if (q.size() == 0) begin
                    check("frame_req_unexpected", 64'(frame_req), 64'(0));
                end else begin
                    cur = q.pop_front();
                    check("underrun", 64'(underrun), 64'(cur.u));
                    mon_active = 1;
                    nbits = 0;
                    cyc   = 0;
                    dw    = '0;
                    lw    = '0;
                end
            end else if (mon_active) begin
                cyc++;
                if (bclk && !bclk_prev) begin
                    dw = {dw[62:0], sdata};
                    lw = {lw[62:0], lrclk};
                    nbits++;
                    if (nbits == 64) begin
                        check("frame_data", dw, {1'b0, cur.d, 8'h00, cur.d, 7'h00});
                        check("frame_lrclk", lw, 64'h00000000FFFFFFFF);
                        check("bclk_timing", 64'(cyc), 64'(127 * BD));
                        mon_active = 0;
                        n_frames++;
                    end
                end
            end
            bclk_prev = bclk;
        end
    end

    initial begin
        repeat (3) @(negedge a_clk);
        check_quiet("reset");
        model_reset();
        reset_n = 1'b1;
        enable  = 1'b1;
        run_phase(12, END_RESET);
        if (!abort) begin
            repeat (2) @(negedge a_clk);
            check_quiet("held_reset");
            model_reset();
            reset_n = 1'b1;
            run_phase(40, END_DISABLE);
        end
        repeat (4) @(negedge a_clk);
        check("frames_checked", 64'(n_frames), 64'(51));
        check("queue_drained", 64'(q.size()), 64'(0));
        check("stray_underrun", 64'(stray), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
